// File: rtl/prize_renderer.sv
// prize_renderer: draws spinning coin prizes from prize_controller's tile
// description, plus a short diagonal "sparkle" on the tile where a prize
// was just collected. The pixel output is registered one cycle after the
// prize_controller outputs. Together with prize_controller's own register,
// that puts it two cycles after pixelX/pixelY.
module prize_renderer #(
    parameter int FRAMES_PER_STEP = 6,
    parameter int SPARKLE_FRAMES  = 16
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [2:0]  prize_type,
    input  logic [10:0] tileTopLeftX,
    input  logic [10:0] tileTopLeftY,
    input  logic [1:0]  random_prize_color,
    input  logic        prize_collision,
    input  logic [10:0] bumpy_x,
    input  logic [10:0] bumpy_y,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic        sparkle_active
);

    localparam int              DIV_W      = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAMES_PER_STEP - 1);
    localparam logic [7:0]      SPK_LOAD   = 8'(SPARKLE_FRAMES);
    localparam logic [0:0]      ST_IDLE    = 1'b0;
    localparam logic [0:0]      ST_SPARKLE = 1'b1;
    localparam logic [2:0]      TYPE_FREE  = 3'b000;
    localparam logic [2:0]      TYPE_REGU  = 3'b001;

    // Coin palette selected by prize_controller's random colour.
    function automatic logic [7:0] coin_color(input logic [1:0] sel);
        case (sel)
            2'b00:   coin_color = 8'hFC;
            2'b01:   coin_color = 8'hF0;
            2'b10:   coin_color = 8'hFF;
            default: coin_color = 8'h1F;
        endcase
    endfunction

    // Spin phase 0..5 maps to frame index 0,1,2,3,2,1.
    // The frame index selects the coin's half-width.
    function automatic logic signed [6:0] half_width(input logic [2:0] phase);
        case (phase)
            3'd0:         half_width = 7'sd16;
            3'd1, 3'd5:   half_width = 7'sd11;
            3'd2, 3'd4:   half_width = 7'sd5;
            default:      half_width = 7'sd2;
        endcase
    endfunction

    // ---- stage p1: pixel coordinates aligned with prize_controller outputs
    logic [10:0] px_p1_q, py_p1_q;

    // Delay the raw pixel position by one cycle to match the tile description.
    always_ff @(posedge clk) begin
        px_p1_q <= pixelX;
        py_p1_q <= pixelY;
    end

    logic [10:0]       off_x_full, off_y_full;
    logic [5:0]        off_x, off_y;
    logic signed [6:0] dx, hw;

    assign off_x_full = px_p1_q - tileTopLeftX;
    assign off_y_full = py_p1_q - tileTopLeftY;
    assign off_x      = off_x_full[5:0];
    assign off_y      = off_y_full[5:0];
    assign dx         = $signed({1'b0, off_x}) - 7'sd32;

    // ---- spin animation: frame divider and phase
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       phase_q, phase_d;

    // Count frames; every FRAMES_PER_STEP frames, advance the phase 0..5.
    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        if (startOfFrame) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Spin state registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_q   <= '0;
            phase_q <= 3'd0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

    assign hw = half_width(phase_q);

    // ---- sparkle FSM
    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] sx_q, sx_d, sy_q, sy_d;
    logic        coll_prev_q, armed_q, armed_d;
    logic        coll_rise;

    // armed_q is cleared by reset and set once the collision input is seen low.
    // A collision that is already high when reset is released cannot trigger.
    // It must fall and rise again first.
    assign armed_d   = armed_q | ~prize_collision;
    assign coll_rise = prize_collision & ~coll_prev_q & armed_q;

    // Trigger or retrigger on a collision edge (load beats decrement).
    // Otherwise, count frames down while sparkling.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        if (coll_rise) begin
            sx_d    = {bumpy_x[10:6], 6'b0};
            sy_d    = {bumpy_y[10:6], 6'b0};
            cnt_d   = SPK_LOAD;
            state_d = ST_SPARKLE;
        end else if (state_q == ST_SPARKLE && startOfFrame) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Sparkle state registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            sx_q        <= 11'd0;
            sy_q        <= 11'd0;
            coll_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            coll_prev_q <= prize_collision;
            armed_q     <= armed_d;
        end
    end

    assign sparkle_active = (state_q == ST_SPARKLE);

    // ---- pixel classification
    logic       coin_hit, sparkle_hit, draw_d;
    logic [5:0] diag_sum;
    logic [7:0] rgb_d;

    assign diag_sum    = off_x + off_y;
    assign coin_hit    = (prize_type == TYPE_REGU) && (dx >= -hw) && (dx < hw)
                         && (off_y >= 6'd16) && (off_y < 6'd48);
    assign sparkle_hit = sparkle_active && (tileTopLeftX == sx_q) && (tileTopLeftY == sy_q)
                         && (prize_type == TYPE_FREE)
                         && ((off_x == off_y) || (diag_sum == 6'd63));

    // Coin has priority over sparkle; the colour is forced to zero when nothing is drawn.
    always_comb begin
        draw_d = coin_hit | sparkle_hit;
        rgb_d  = 8'h00;
        if (coin_hit) begin
            rgb_d = coin_color(random_prize_color);
        end else if (sparkle_hit) begin
            rgb_d = cnt_q[0] ? 8'hFF : 8'hFC;
        end
    end

    // ---- stage p2: registered drawing request and colour
    logic       draw_p2_q;
    logic [7:0] rgb_p2_q;

    // Output register for the VGA mux.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            draw_p2_q <= 1'b0;
            rgb_p2_q  <= 8'h00;
        end else begin
            draw_p2_q <= draw_d;
            rgb_p2_q  <= rgb_d;
        end
    end

    assign drawingRequest = draw_p2_q;
    assign RGBout         = rgb_p2_q;

endmodule

// File: tb/tb_prize_renderer.sv
// Directed bench for prize_renderer: reset, coin rendering with table vectors,
// spin animation, sparkle lifetime, retrigger and priority.
module tb_prize_renderer;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = '0, pixelY = '0;
    logic [2:0]  prize_type = '0;
    logic [10:0] tileTopLeftX = '0, tileTopLeftY = '0;
    logic [1:0]  random_prize_color = '0;
    logic        prize_collision = 1'b0;
    logic [10:0] bumpy_x = '0, bumpy_y = '0;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic        sparkle_active;

    int checks = 0;
    int failures = 0;

    prize_renderer #(.FRAMES_PER_STEP(6), .SPARKLE_FRAMES(16)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .prize_type(prize_type),
        .tileTopLeftX(tileTopLeftX), .tileTopLeftY(tileTopLeftY),
        .random_prize_color(random_prize_color), .prize_collision(prize_collision),
        .bumpy_x(bumpy_x), .bumpy_y(bumpy_y),
        .drawingRequest(drawingRequest), .RGBout(RGBout), .sparkle_active(sparkle_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] px, py;
        logic [2:0]  pt;
        logic [10:0] tx, ty;
        logic [1:0]  col;
        logic        dr;
        logic [7:0]  rgb;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input int px, py, pt, tx, ty, col, dr, rgb);
        vec_t v;
        v.px = 11'(px); v.py = 11'(py); v.pt = 3'(pt);
        v.tx = 11'(tx); v.ty = 11'(ty); v.col = 2'(col);
        v.dr = 1'(dr); v.rgb = 8'(rgb);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_px(input string name, input logic dr, input logic [7:0] rgb);
        check({name, ".dr"}, {31'd0, drawingRequest}, {31'd0, dr});
        check({name, ".rgb"}, {24'd0, RGBout}, {24'd0, rgb});
    endtask

    // Called #1 after a rising edge. Drive the pixel, then one cycle later the
    // tile description. The output is sampled two edges after the pixel.
    task automatic apply(input int px, py, pt, tx, ty, col);
        pixelX = 11'(px); pixelY = 11'(py);
        @(posedge clk); #1;
        prize_type = 3'(pt); tileTopLeftX = 11'(tx); tileTopLeftY = 11'(ty);
        random_prize_color = 2'(col);
        @(posedge clk); #1;
    endtask

    task automatic pulse_sof();
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) pulse_sof();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset with collision high and frame pulses
        prize_collision = 1'b1;
        #2 resetN = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1 startOfFrame = ~startOfFrame;
        end
        startOfFrame = 1'b0;
        check("rst_dr", {31'd0, drawingRequest}, 32'd0);
        check("rst_rgb", {24'd0, RGBout}, 32'd0);
        check("rst_spk", {31'd0, sparkle_active}, 32'd0);
        @(posedge clk); #1 resetN = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("held_no_trig", {31'd0, sparkle_active}, 32'd0);
        prize_collision = 1'b0; bumpy_x = 11'd200; bumpy_y = 11'd70;
        @(posedge clk); #1;
        prize_collision = 1'b1;
        @(posedge clk); #1;
        check("retrig_after_fall", {31'd0, sparkle_active}, 32'd1);
        apply(202, 74, 0, 192, 64, 0);
        check_px("pre_async_rst", 1'b1, 8'hFC);
        // async reset mid-sparkle, no clock edge in between
        resetN = 1'b0;
        #2;
        check("async_dr", {31'd0, drawingRequest}, 32'd0);
        check("async_rgb", {24'd0, RGBout}, 32'd0);
        check("async_spk", {31'd0, sparkle_active}, 32'd0);
        @(posedge clk); #1 resetN = 1'b1; prize_collision = 1'b0;
        @(posedge clk); #1;

        // ---------------- latency: exactly 2 cycles after the pixel
        apply(79, 100, 1, 64, 64, 1);
        check_px("lat_pre", 1'b0, 8'h00);
        pixelX = 11'd111; pixelY = 11'd100;
        @(posedge clk); #1;
        check_px("lat_e1", 1'b0, 8'h00);
        @(posedge clk); #1;
        check_px("lat_e2", 1'b1, 8'hF0);

        // ---------------- coin table, phase 0 (hw=16), tile (64,64)
        tbl[0]  = mk(111, 100, 1, 64, 64, 1, 1, 8'hF0); // dx=15
        tbl[1]  = mk(112, 100, 1, 64, 64, 1, 0, 8'h00); // dx=16
        tbl[2]  = mk(80,  100, 1, 64, 64, 1, 1, 8'hF0); // dx=-16
        tbl[3]  = mk(79,  100, 1, 64, 64, 1, 0, 8'h00); // dx=-17
        tbl[4]  = mk(96,  112, 1, 64, 64, 1, 0, 8'h00); // offY=48
        tbl[5]  = mk(96,  111, 1, 64, 64, 1, 1, 8'hF0); // offY=47
        tbl[6]  = mk(96,  80,  1, 64, 64, 0, 1, 8'hFC); // offY=16
        tbl[7]  = mk(96,  79,  1, 64, 64, 0, 0, 8'h00); // offY=15
        tbl[8]  = mk(96,  96,  1, 64, 64, 2, 1, 8'hFF);
        tbl[9]  = mk(96,  96,  1, 64, 64, 3, 1, 8'h1F);
        tbl[10] = mk(96,  96,  0, 64, 64, 1, 0, 8'h00); // FREE, no sparkle
        tbl[11] = mk(96,  96,  3, 64, 64, 1, 0, 8'h00); // reserved
        tbl[12] = mk(160, 96,  1, 128, 64, 1, 1, 8'hF0); // other tile, dx=0
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].px, tbl[i].py, tbl[i].pt, tbl[i].tx, tbl[i].ty, tbl[i].col);
            check_px($sformatf("vec%0d", i), tbl[i].dr, tbl[i].rgb);
        end

        // ---------------- spin animation
        pulses(6); // phase 1, hw=11
        apply(84, 100, 1, 64, 64, 1);  check_px("ph1_dxm12", 1'b0, 8'h00);
        apply(85, 100, 1, 64, 64, 1);  check_px("ph1_dxm11", 1'b1, 8'hF0);
        apply(106, 100, 1, 64, 64, 1); check_px("ph1_dx10", 1'b1, 8'hF0);
        apply(107, 100, 1, 64, 64, 1); check_px("ph1_dx11", 1'b0, 8'h00);
        pulses(6); // phase 2, hw=5
        apply(91, 100, 1, 64, 64, 1);  check_px("ph2_dxm5", 1'b1, 8'hF0);
        apply(90, 100, 1, 64, 64, 1);  check_px("ph2_dxm6", 1'b0, 8'h00);
        pulses(6); // phase 3, hw=2
        apply(94, 100, 1, 64, 64, 1);  check_px("ph3_dxm2", 1'b1, 8'hF0);
        apply(93, 100, 1, 64, 64, 1);  check_px("ph3_dxm3", 1'b0, 8'h00);
        apply(98, 100, 1, 64, 64, 1);  check_px("ph3_dx2", 1'b0, 8'h00);
        pulses(6); // phase 4, hw=5
        apply(91, 100, 1, 64, 64, 1);  check_px("ph4_dxm5", 1'b1, 8'hF0);
        apply(90, 100, 1, 64, 64, 1);  check_px("ph4_dxm6", 1'b0, 8'h00);
        pulses(6); // phase 5, hw=11
        apply(85, 100, 1, 64, 64, 1);  check_px("ph5_dxm11", 1'b1, 8'hF0);
        apply(84, 100, 1, 64, 64, 1);  check_px("ph5_dxm12", 1'b0, 8'h00);
        pulses(6); // phase 0 again, hw=16
        apply(84, 100, 1, 64, 64, 1);  check_px("ph0_dxm12", 1'b1, 8'hF0);
        apply(80, 100, 1, 64, 64, 1);  check_px("ph0_dxm16", 1'b1, 8'hF0);

        // ---------------- sparkle at tile (192,64)
        bumpy_x = 11'd200; bumpy_y = 11'd70; prize_collision = 1'b1;
        @(posedge clk); #1;
        check("spk_rise", {31'd0, sparkle_active}, 32'd1);
        apply(202, 74, 0, 192, 64, 0);  check_px("spk_diag", 1'b1, 8'hFC);
        apply(202, 117, 0, 192, 64, 0); check_px("spk_anti", 1'b1, 8'hFC);
        apply(203, 74, 0, 192, 64, 0);  check_px("spk_off", 1'b0, 8'h00);
        apply(202, 74, 3, 192, 64, 0);  check_px("spk_reserved", 1'b0, 8'h00);
        apply(224, 96, 1, 192, 64, 3);  check_px("spk_coin_prio", 1'b1, 8'h1F);
        apply(224, 96, 0, 192, 64, 3);  check_px("spk_center", 1'b1, 8'hFC);
        pulse_sof(); // counter 15, collision still high: no reload
        apply(202, 74, 0, 192, 64, 0);  check_px("spk_cnt15", 1'b1, 8'hFF);
        prize_collision = 1'b0;
        pulses(14);
        check("spk_after15", {31'd0, sparkle_active}, 32'd1);
        pulse_sof();
        check("spk_after16", {31'd0, sparkle_active}, 32'd0);
        apply(202, 74, 0, 192, 64, 0);  check_px("spk_gone", 1'b0, 8'h00);

        // ---------------- retrigger with simultaneous startOfFrame
        prize_collision = 1'b1;
        @(posedge clk); #1;
        check("rt_first", {31'd0, sparkle_active}, 32'd1);
        prize_collision = 1'b0;
        pulses(3);
        bumpy_x = 11'd10; bumpy_y = 11'd10; prize_collision = 1'b1; startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        check("rt_active", {31'd0, sparkle_active}, 32'd1);
        apply(5, 5, 0, 0, 0, 0);        check_px("rt_new_tile_cnt16", 1'b1, 8'hFC);
        apply(202, 74, 0, 192, 64, 0);  check_px("rt_old_tile", 1'b0, 8'h00);
        prize_collision = 1'b0;
        pulses(15);
        check("rt_after15", {31'd0, sparkle_active}, 32'd1);
        pulse_sof();
        check("rt_after16", {31'd0, sparkle_active}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
